stream_palindrome_checker: RTL
==============================

STREAM_PALINDROME_CHECKER -- requirements
Module: stream_palindrome_checker

Interface
REQ-001 SHALL have parameter SYM_W, default 8: bits per symbol.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum symbols per packet, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: input symbol valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a symbol.
REQ-007 SHALL have port in_data, input, SYM_W: symbol.
REQ-008 SHALL have port in_last, input, 1: final symbol of packet.
REQ-009 SHALL have port res_valid, output, 1: result available.
REQ-010 SHALL have port res_ready, input, 1: result consumed.
REQ-011 SHALL have port res_pal, output, 1: packet is a palindrome.
REQ-012 SHALL have port res_len, output, $clog2(MAX_LEN+1): symbols in packet.
REQ-013 SHALL have port res_ovf, output, 1: packet truncated at MAX_LEN.

Function
REQ-014 SHALL implement states COLLECT, CHECK, RESULT.
REQ-015 SHALL accept a beat when in_valid && in_ready; in_ready = (state==COLLECT), combinational from state only.
REQ-016 SHALL store accepted symbols at buffer index cnt and increment cnt.
REQ-017 SHALL end a packet on an accepted beat with in_last=1, or on the accepted beat bringing cnt to MAX_LEN (forced end, res_ovf=1 unless in_last=1 on that beat).
REQ-018 SHALL set len = final cnt and P = floor(len/2); a symbol is compared only against its mirror, buf[i] vs buf[len-1-i], i = 0..P-1.
REQ-019 SHALL perform exactly one pair compare per cycle in CHECK; middle symbol of odd length is never compared.
REQ-020 SHALL, if P==0 (len=1), go COLLECT->RESULT directly with res_pal=1.
REQ-021 SHALL, with last beat accepted at cycle t, assert res_valid at t+P+1 (full scan).
REQ-022 SHALL hold res_valid, res_pal, res_len, res_ovf stable until res_valid && res_ready, then clear cnt and return to COLLECT next cycle.
REQ-023 SHALL compare SYM_W bits exactly; no masking.

Reset
REQ-024 SHALL on rst_n low, at any time including mid-packet or mid-CHECK, enter COLLECT, clear cnt, res_valid=0, res_pal=0, res_len=0, res_ovf=0, discarding partial packets; buffer contents need not reset.
REQ-025 SHALL, after rst_n deasserts, assert in_ready in the first cycle.

Configuration
REQ-026 SHALL honour macro PAL_EARLY_EXIT_EN.
REQ-027 SHALL, with PAL_EARLY_EXIT_EN defined, leave CHECK the cycle after the first mismatch (res_valid at t+k+1, k = 1-based index of mismatching pair); matches still take t+P+1.
REQ-028 SHALL, without PAL_EARLY_EXIT_EN, always use the full P-cycle scan of REQ-021.

Structure
REQ-029 SHALL place state enum pal_state_t and function len_w(MAX_LEN) in package pal_pkg.
REQ-030 SHALL implement the symbol store as sub-module pal_buffer (1 write port, 2 combinational read ports, SYM_W x MAX_LEN).

Verification (SYM_W=8, MAX_LEN=16)
REQ-031 SHALL check "ABCBA" (last on 'A'): res_pal=1, res_len=5, res_ovf=0, res_valid at t+3.
REQ-032 SHALL check "ABCD": res_pal=0, res_len=4; full scan valid at t+3, early-exit build valid at t+2.
REQ-033 SHALL check single 0x5A with last: res_valid at t+1, res_pal=1, res_len=1.
REQ-034 SHALL check 20 beats 0x11, no last: first 16 give res_ovf=1, res_pal=1, res_len=16; in_ready=0 until res_ready; remaining 4 form the next packet.
REQ-035 SHALL check res_ready held low 5 cycles: outputs stable, in_ready=0 throughout.
REQ-036 SHALL check rst_n pulsed low during CHECK of 16-symbol packet: res_valid=0, in_ready=1 after release, next packet "XX" gives res_pal=1.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared types and width helpers for the stream palindrome checker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pal_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    RESULT  = 2'd2
  } pal_state_t;

  // Width able to hold a symbol count of 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of a buffer index 0..max_len-1 (at least one bit).
  function automatic int addr_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/pal_buffer.sv
// Symbol store: one synchronous write port, two combinational read ports.
// Latency: write visible on the cycle after the write edge; reads are same-cycle.
// Backpressure: none; the writer decides when to write.
module pal_buffer
  import pal_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [addr_w(MAX_LEN)-1:0]  wr_addr,
  input  logic [SYM_W-1:0]            wr_data,
  input  logic [addr_w(MAX_LEN)-1:0]  rd_addr_a,
  output logic [SYM_W-1:0]            rd_data_a,
  input  logic [addr_w(MAX_LEN)-1:0]  rd_addr_b,
  output logic [SYM_W-1:0]            rd_data_b
);

  logic [SYM_W-1:0] mem [MAX_LEN];

  // Contents carry no reset; a packet always overwrites what it later reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/stream_palindrome_checker.sv
// Collects a packet of symbols and reports whether it reads the same reversed.
// Latency: result valid P+1 cycles after the last beat (P = len/2); PAL_EARLY_EXIT_EN stops at first mismatch.
// Backpressure: in_ready only while collecting; result held until res_ready, then collection resumes.
module stream_palindrome_checker
  import pal_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SYM_W-1:0]           in_data,
  input  logic                       in_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_pal,
  output logic [len_w(MAX_LEN)-1:0]  res_len,
  output logic                       res_ovf
);

  localparam int LW = len_w(MAX_LEN);
  localparam int AW = addr_w(MAX_LEN);

  pal_state_t       state;
  pal_state_t       state_nxt;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    cnt_inc;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    len_q;
  logic             pal_q;
  logic             ovf_q;
  logic             accept;
  logic             pkt_end;
  logic             pair_eq;
  logic             last_pair;
  logic [AW-1:0]    rd_lo;
  logic [AW-1:0]    rd_hi;
  logic [SYM_W-1:0] sym_lo;
  logic [SYM_W-1:0] sym_hi;

  // Acceptance is derived from state directly so it does not loop through the FSM block.
  assign accept    = in_valid && (state == COLLECT);
  assign cnt_inc   = cnt + LW'(1);
  assign pkt_end   = accept && (in_last || (cnt_inc == LW'(MAX_LEN)));

  // Pair idx is compared against its mirror len-1-idx; the odd middle is never reached.
  assign rd_lo     = AW'(idx);
  assign rd_hi     = AW'(len_q - LW'(1) - idx);
  assign pair_eq   = (sym_lo == sym_hi);
  assign last_pair = ((idx + LW'(1)) == (len_q >> 1));

  pal_buffer #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk       (clk),
    .wr_en     (accept),
    .wr_addr   (AW'(cnt)),
    .wr_data   (in_data),
    .rd_addr_a (rd_lo),
    .rd_data_a (sym_lo),
    .rd_addr_b (rd_hi),
    .rd_data_b (sym_hi)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (pkt_end) begin
          // A single-symbol packet has no pairs and skips the scan.
          state_nxt = (cnt_inc == LW'(1)) ? RESULT : CHECK;
        end
      end
      CHECK: begin
`ifdef PAL_EARLY_EXIT_EN
        if (!pair_eq || last_pair) begin
          state_nxt = RESULT;
        end
`else
        if (last_pair) begin
          state_nxt = RESULT;
        end
`endif
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Datapath: symbol count, pair index and the registered result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      len_q <= '0;
      pal_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (pkt_end) begin
              len_q <= cnt_inc;
              ovf_q <= !in_last;
              pal_q <= 1'b1;
              idx   <= '0;
            end
          end
        end
        CHECK: begin
          idx <= idx + LW'(1);
          if (!pair_eq) begin
            pal_q <= 1'b0;
          end
        end
        RESULT: begin
          if (res_ready) begin
            cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_pal = pal_q;
  assign res_len = len_q;
  assign res_ovf = ovf_q;

endmodule
